// File: rtl/video_mode_sequencer.sv
// ---------------------------------------------------------------------------
// video_mode_sequencer
//
// Owns the run-time configuration word of the video output pipeline.
// A requested word must be stable for STABLE_CYCLES clocks. After that the
// picture is blanked on a vertical-sync boundary. The new word is applied one
// frame later, and blank is held for BLANK_FRAMES more vsync events. This
// keeps the downstream chain from ever switching mid-frame. If vsync goes
// missing, a wrapping timeout counter stands in for it.
//
// Ports:
//   clk_sys    in   system clock (same as the video pipeline)
//   reset      in   asynchronous active-high reset
//   cfg_req    in   requested configuration word, may change at any time
//   VSync      in   core vertical sync, active level set by VS_POL
//   cfg_out    out  applied configuration word (registered)
//   cfg_strobe out  one-cycle pulse in the cycle cfg_out takes a new value
//   blank      out  forces pipeline RGB to zero while high (registered)
//   busy       out  high whenever a change sequence is in progress
// ---------------------------------------------------------------------------
module video_mode_sequencer #(
    parameter int                   CFG_WIDTH     = 16,
    parameter logic [CFG_WIDTH-1:0] CFG_DEFAULT   = '0,
    parameter int                   STABLE_CYCLES = 1024,
    parameter int                   BLANK_FRAMES  = 2,
    parameter int                   VS_TIMEOUT_W  = 22,
    parameter logic                 VS_POL        = 1'b0
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [CFG_WIDTH-1:0] cfg_req,
    input  logic                 VSync,
    output logic [CFG_WIDTH-1:0] cfg_out,
    output logic                 cfg_strobe,
    output logic                 blank,
    output logic                 busy
);

    localparam int SCNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int FCNT_W = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STABLE_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLANK_FRAMES - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, WAIT_VS, BLANK1, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [CFG_WIDTH-1:0]    cfg_out_q, cfg_out_d;
    logic [CFG_WIDTH-1:0]    pend_q, pend_d;
    logic                    cfg_strobe_q, cfg_strobe_d;
    logic                    blank_q, blank_d;
    logic [SCNT_W-1:0]       scnt_q, scnt_d;
    logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
    logic [VS_TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                    vs_prev_q, vs_prev_d;

    logic vs_act, vs_start, tmo_run, tmo_hit, vs_evt;

    assign vs_act    = (VSync == VS_POL);
    assign vs_start  = vs_act & ~vs_prev_q;
    // The timeout only runs while waiting on vsync, so it only matters there.
    assign tmo_run   = (state_q == WAIT_VS) || (state_q == BLANK1) || (state_q == HOLD);
    assign tmo_hit   = tmo_run && (tmo_q == '1);
    // A coincident real edge and timeout collapse into a single event.
    assign vs_evt    = vs_start | tmo_hit;
    assign vs_prev_d = vs_act;

    always_comb begin
        state_d      = state_q;
        cfg_out_d    = cfg_out_q;
        pend_d       = pend_q;
        cfg_strobe_d = 1'b0;
        blank_d      = blank_q;
        scnt_d       = scnt_q;
        fcnt_d       = fcnt_q;

        case (state_q)
            IDLE: begin
                if (cfg_req != cfg_out_q) begin
                    pend_d  = cfg_req;
                    scnt_d  = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // Request reverted to what is already applied: abandon quietly.
                if (cfg_req == cfg_out_q) begin
                    state_d = IDLE;
                end else if (cfg_req != pend_q) begin
                    pend_d = cfg_req;
                    scnt_d = '0;
                end else if (scnt_q == SCNT_LAST) begin
                    state_d = WAIT_VS;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            WAIT_VS: begin
                if (vs_evt) begin
                    blank_d = 1'b1;
                    state_d = BLANK1;
                end
            end
            BLANK1: begin
                // A full blanked frame has passed: the word switches here.
                if (vs_evt) begin
                    cfg_out_d    = pend_q;
                    cfg_strobe_d = 1'b1;
                    fcnt_d       = '0;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (vs_evt) begin
                    if (fcnt_q == FCNT_LAST) begin
                        blank_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Timeout restarts on every real vsync and on every state change.
        if (vs_start || (state_d != state_q)) begin
            tmo_d = '0;
        end else if (tmo_run) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = tmo_q;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cfg_out_q    <= CFG_DEFAULT;
            pend_q       <= '0;
            cfg_strobe_q <= 1'b0;
            blank_q      <= 1'b0;
            scnt_q       <= '0;
            fcnt_q       <= '0;
            tmo_q        <= '0;
            vs_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_out_q    <= cfg_out_d;
            pend_q       <= pend_d;
            cfg_strobe_q <= cfg_strobe_d;
            blank_q      <= blank_d;
            scnt_q       <= scnt_d;
            fcnt_q       <= fcnt_d;
            tmo_q        <= tmo_d;
            vs_prev_q    <= vs_prev_d;
        end
    end

    assign cfg_out    = cfg_out_q;
    assign cfg_strobe = cfg_strobe_q;
    assign blank      = blank_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_video_mode_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for video_mode_sequencer.
//
// Three instances share one clock and reset:
//   idx 0 "main": active-low VSync every 1000 clocks
//   idx 1 "pol":  same timing with inverted VSync and VS_POL=1
//   idx 2 "tmo":  VS_TIMEOUT_W=4 with VSync held inactive
// A logger records the cycle numbers of blank rise/fall, strobe and busy fall.
// It also records the cycle of each VSync active edge.
// Words expected on main's cfg_out are queued as stimulus is driven. They are
// popped on every main strobe.
// ---------------------------------------------------------------------------
module tb_video_mode_sequencer;

    localparam int W = 16;
    localparam int SC = 4;
    localparam int EV_BR = 0, EV_ST = 1, EV_BF = 2;

    logic          clk;
    logic          rst;
    logic [W-1:0]  cfg_req, cfg_req_t;
    logic          vs_m, vs_p, vs_t;
    logic [W-1:0]  cfg_out_m, cfg_out_p, cfg_out_t;
    logic          strobe_m, strobe_p, strobe_t;
    logic          blank_m, blank_p, blank_t;
    logic          busy_m, busy_p, busy_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int vph = 0;
    int vs_log[$];
    logic [W-1:0] sb[$];

    int br[3]    = '{-1, -1, -1};
    int bf[3]    = '{-1, -1, -1};
    int st[3]    = '{-1, -1, -1};
    int busyf[3] = '{-1, -1, -1};
    int nst[3]   = '{0, 0, 0};
    logic [2:0] prv_blank = '0;
    logic [2:0] prv_busy  = '0;
    logic       vs_prev_tb = 1'b1;

    wire [2:0] blank_v  = {blank_t, blank_p, blank_m};
    wire [2:0] busy_v   = {busy_t, busy_p, busy_m};
    wire [2:0] strobe_v = {strobe_t, strobe_p, strobe_m};

    video_mode_sequencer #(.CFG_WIDTH(W), .CFG_DEFAULT(16'h0000), .STABLE_CYCLES(SC),
        .BLANK_FRAMES(2), .VS_TIMEOUT_W(16), .VS_POL(1'b0)) u_main (
        .clk_sys(clk), .reset(rst), .cfg_req(cfg_req), .VSync(vs_m),
        .cfg_out(cfg_out_m), .cfg_strobe(strobe_m), .blank(blank_m), .busy(busy_m));

    video_mode_sequencer #(.CFG_WIDTH(W), .CFG_DEFAULT(16'h0000), .STABLE_CYCLES(SC),
        .BLANK_FRAMES(2), .VS_TIMEOUT_W(16), .VS_POL(1'b1)) u_pol (
        .clk_sys(clk), .reset(rst), .cfg_req(cfg_req), .VSync(vs_p),
        .cfg_out(cfg_out_p), .cfg_strobe(strobe_p), .blank(blank_p), .busy(busy_p));

    video_mode_sequencer #(.CFG_WIDTH(W), .CFG_DEFAULT(16'h0000), .STABLE_CYCLES(SC),
        .BLANK_FRAMES(2), .VS_TIMEOUT_W(4), .VS_POL(1'b0)) u_tmo (
        .clk_sys(clk), .reset(rst), .cfg_req(cfg_req_t), .VSync(vs_t),
        .cfg_out(cfg_out_t), .cfg_strobe(strobe_t), .blank(blank_t), .busy(busy_t));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // VSync: active for 20 of every 1000 clocks, changed on the falling edge.
    initial begin
        vs_m = 1'b1;
        vs_p = 1'b0;
        forever begin
            @(negedge clk);
            vph  = (vph + 1) % 1000;
            vs_m = (vph < 20) ? 1'b0 : 1'b1;
            vs_p = ~vs_m;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!vs_m && vs_prev_tb) vs_log.push_back(cyc);
        vs_prev_tb = vs_m;
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (blank_v[i] && !prv_blank[i]) br[i] = cyc;
            if (!blank_v[i] && prv_blank[i]) bf[i] = cyc;
            if (!busy_v[i] && prv_busy[i]) busyf[i] = cyc;
            if (strobe_v[i]) begin
                st[i] = cyc;
                nst[i]++;
            end
        end
        prv_blank = blank_v;
        prv_busy  = busy_v;
        if (strobe_m) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_strobe", 32'(cfg_out_m), 32'hFFFF_FFFF);
            end else begin
                chk("sb_cfg_out", 32'(cfg_out_m), 32'(sb.pop_front()));
            end
        end
    end

    function automatic int evt(input int idx, input int which);
        if (which == EV_BR) return br[idx];
        if (which == EV_ST) return st[idx];
        return bf[idx];
    endfunction

    function automatic int next_edge(input int c);
        int r;
        r = -1;
        for (int i = 0; i < vs_log.size(); i++) begin
            if (r < 0 && vs_log[i] > c) r = vs_log[i];
        end
        return r;
    endfunction

    task automatic wait_evt(input int idx, input int which, input int after,
                            input int budget, input string tag);
        int k;
        k = 0;
        while (evt(idx, which) <= after && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (evt(idx, which) <= after) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s_timeout: no event within %0d cycles", tag, budget);
        end
    endtask

    task automatic wait_vph(input int v);
        int k;
        k = 0;
        while (vph != v && k < 1100) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int c0, c1, f, n0, n1, e1, e2, e4;
        rst = 1'b1;
        cfg_req = '0;
        cfg_req_t = '0;
        vs_t = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cfg_out", 32'(cfg_out_m), 0);
        chk("rst_blank", 32'(blank_m), 0);
        chk("rst_busy", 32'(busy_m), 0);
        chk("rst_strobe", 32'(strobe_m), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_busy", 32'(busy_m), 0);

        // Cancel: request reverts before it has settled.
        wait_vph(100);
        c0 = cyc; n0 = nst[0];
        cfg_req = 16'h0005;
        @(negedge clk);
        chk("cancel_busy", 32'(busy_m), 1);
        @(negedge clk);
        cfg_req = 16'h0000;
        repeat (4) @(negedge clk);
        chk("cancel_idle", 32'(busy_m), 0);
        repeat (1100) @(negedge clk);
        chk("cancel_no_strobe", 32'(nst[0]), 32'(n0));
        chk("cancel_no_blank", 32'(br[0]), 32'(-1));
        chk("cancel_cfg", 32'(cfg_out_m), 0);

        // Normal change on both polarities.
        wait_vph(100);
        c0 = cyc; n0 = nst[0]; n1 = nst[1];
        cfg_req = 16'h0025;
        sb.push_back(16'h0025);
        @(negedge clk);
        chk("nrm_busy_rise", 32'(busy_m), 1);
        chk("pol_busy_rise", 32'(busy_p), 1);
        chk("nrm_blank_low", 32'(blank_m), 0);
        wait_evt(0, EV_BF, c0, 5000, "nrm_blank_fall");
        wait_evt(1, EV_BF, c0, 10, "pol_blank_fall");
        e1 = next_edge(c0);
        e2 = next_edge(e1);
        e4 = next_edge(next_edge(e2));
        chk("nrm_blank_rise", 32'(br[0]), 32'(e1));
        chk("nrm_strobe_cyc", 32'(st[0]), 32'(e2));
        chk("nrm_nstrobe", 32'(nst[0]), 32'(n0 + 1));
        chk("nrm_blank_fall", 32'(bf[0]), 32'(e4));
        chk("nrm_busy_fall", 32'(busyf[0]), 32'(e4));
        chk("nrm_cfg", 32'(cfg_out_m), 32'h25);
        chk("pol_blank_rise", 32'(br[1]), 32'(e1));
        chk("pol_strobe_cyc", 32'(st[1]), 32'(e2));
        chk("pol_nstrobe", 32'(nst[1]), 32'(n1 + 1));
        chk("pol_blank_fall", 32'(bf[1]), 32'(e4));
        chk("pol_cfg", 32'(cfg_out_p), 32'h25);

        // Request arriving during HOLD is kept and applied afterwards.
        wait_vph(100);
        c0 = cyc; n0 = nst[0];
        cfg_req = 16'h0011;
        sb.push_back(16'h0011);
        wait_evt(0, EV_ST, c0, 3000, "hold_first_strobe");
        @(negedge clk);
        c1 = cyc;
        cfg_req = 16'h0007;
        sb.push_back(16'h0007);
        wait_evt(0, EV_BF, c1, 3000, "hold_first_fall");
        f = bf[0];
        chk("hold_first_cfg", 32'(cfg_out_m), 32'h11);
        chk("hold_busy_at_fall", 32'(busy_m), 0);
        @(negedge clk);
        chk("hold_second_busy", 32'(busy_m), 1);
        wait_evt(0, EV_BF, f, 5000, "hold_second_fall");
        chk("hold_final_cfg", 32'(cfg_out_m), 32'h7);
        chk("hold_nstrobe", 32'(nst[0]), 32'(n0 + 2));

        // Debounce: only the value that finally holds is applied.
        wait_vph(100);
        c0 = cyc; n0 = nst[0];
        sb.push_back(16'h0002);
        cfg_req = 16'h0001; repeat (2) @(negedge clk);
        cfg_req = 16'h0002; repeat (2) @(negedge clk);
        cfg_req = 16'h0001; repeat (2) @(negedge clk);
        cfg_req = 16'h0002;
        wait_evt(0, EV_BF, c0, 5000, "deb_fall");
        chk("deb_nstrobe", 32'(nst[0]), 32'(n0 + 1));
        chk("deb_cfg", 32'(cfg_out_m), 32'h2);
        chk("deb_blank_rise", 32'(br[0]), 32'(next_edge(c0)));

        // Asynchronous reset in the middle of HOLD.
        wait_vph(100);
        c0 = cyc;
        cfg_req = 16'h005A;
        sb.push_back(16'h005A);
        wait_evt(0, EV_ST, c0, 3000, "rsth_strobe");
        @(negedge clk);
        chk("rsth_pre_blank", 32'(blank_m), 1);
        chk("rsth_pre_cfg", 32'(cfg_out_m), 32'h5A);
        #2 rst = 1'b1;
        #1;
        chk("rsth_cfg", 32'(cfg_out_m), 0);
        chk("rsth_blank", 32'(blank_m), 0);
        chk("rsth_busy", 32'(busy_m), 0);
        chk("rsth_pol_blank", 32'(blank_p), 0);
        cfg_req = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", 32'(busy_m), 0);
        chk("post_rst_blank", 32'(blank_m), 0);
        chk("post_rst_cfg", 32'(cfg_out_m), 0);
        chk("sb_drained", 32'(sb.size()), 0);

        // Missing vsync: the 16-clock timeout paces the whole sequence.
        c0 = cyc;
        cfg_req_t = 16'h0003;
        wait_evt(2, EV_BF, c0, 300, "tmo_fall");
        chk("tmo_rise_window",
            32'((br[2] >= c0 + 1 + SC + 16) && (br[2] <= c0 + 2 + SC + 16)), 1);
        chk("tmo_strobe_cyc", 32'(st[2]), 32'(br[2] + 16));
        chk("tmo_blank_fall", 32'(bf[2]), 32'(st[2] + 32));
        chk("tmo_cfg", 32'(cfg_out_t), 32'h3);
        chk("tmo_nstrobe", 32'(nst[2]), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
